mux_dff_pipe: RTL and testbench
===============================

// Module: mux_dff_pipe
// PURPOSE
//  Parametrised successor to the single-bit mux-built D flip-flop: a WIDTH-bit,
//  DEPTH-stage elastic register pipeline. Each stage is a mux-hold register
//  (load mux: new data or own output). Stages carry valid/ready flow control.
//  Used as a retiming/buffering slice between producer and consumer datapaths.
// PARAMETERS
//  WIDTH      8   data bits per stage (>=1)
//  DEPTH      4   number of register stages (>=1)
//  RESET_VAL  0   data value loaded into every stage on reset
// PORTS
//  clk        in   1                        rising-edge clock
//  rst_n      in   1                        async active-low reset
//  in_valid   in   1                        producer has data on in_data
//  in_ready   out  1                        pipeline accepts in_data this cycle
//  in_data    in   WIDTH                    input word
//  out_valid  out  1                        stage DEPTH-1 holds valid data
//  out_ready  in   1                        consumer takes out_data this cycle
//  out_data   out  WIDTH                    stage DEPTH-1 data
//  occupancy  out  $clog2(DEPTH+1)          count of valid stages
//  flush      in   1                        sync clear (only with MUX_PIPE_FLUSH_EN)
// BEHAVIOUR
//  - Reset: rst_n is asynchronous and active-low. While low, every stage valid=0,
//    data=RESET_VAL; out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1.
//    Deassertion takes effect on the next rising clk edge.
//  - Per stage i: v[i], d[i]. Advance term adv[DEPTH-1] = out_ready.
//    adv[i] = !v[i+1] | adv[i+1] for i < DEPTH-1.
//  - Stage i loads, via its mux, when !v[i] | adv[i]. Otherwise it holds:
//    the mux selects its own output.
//    Stage 0 loads d<=in_data, v<=in_valid. Stage i>0 loads d<=d[i-1], v<=v[i-1].
//  - in_ready = !v[0] | adv[0]. This path is combinational from out_ready
//    (ripple). A transfer occurs when in_valid & in_ready,
//    or when out_valid & out_ready.
//  - Latency: DEPTH cycles from an accepted input to out_valid, with no stall.
//    Throughput is 1 word/cycle when out_ready is held high.
//  - Bubbles collapse: an invalid stage always loads, so gaps close while the
//    output is stalled.
//  - Full: all v=1 and out_ready=0 -> in_ready=0. All data held stable,
//    occupancy=DEPTH.
//  - Full with out_ready=1 -> in_ready=1. Simultaneous push and pop leaves
//    occupancy unchanged.
//  - Empty: occupancy=0, out_valid=0. out_data holds its last value
//    (don't-care to consumer).
//  - occupancy is a registered count: +1 on push only, -1 on pop only,
//    unchanged on both or neither. It never exceeds DEPTH or drops below 0.
//  - Invalid stages' data may change freely. Valid data is never dropped
//    or duplicated.
//  - Reset mid-operation: all in-flight words are discarded at once.
//    No output glitches to valid.
//  - DEPTH=1 is a single registered slot. in_ready = !v[0] | out_ready.
// CONFIGURATION
//  MUX_PIPE_FLUSH_EN defined:
//    - Adds the flush input. When flush=1 at a clk edge: all v<=0,
//      occupancy<=0, and in_ready is forced to 0 that cycle (no accept).
//    - Data registers hold. Flush has priority over push and pop.
//  MUX_PIPE_FLUSH_EN undefined:
//    - No flush port. Only rst_n clears the pipeline.
// TESTING
//  1 Reset: rst_n=0 mid-stream with occupancy=3 -> same cycle: out_valid=0,
//    occupancy=0, out_data=RESET_VAL.
//  2 Streaming: DEPTH=4, out_ready=1, push 0x01..0x10 back-to-back ->
//    0x01 appears at cycle 4, then one word per cycle in order. in_ready
//    stays 1.
//  3 Fill/stall: out_ready=0, push 0xA0..0xA5 -> 0xA0..0xA3 accepted.
//    in_ready=0 after the 4th. occupancy=4. out_data=0xA0 held.
//  4 Simultaneous: full pipe, out_ready=1 with in_valid=1 for 1 cycle ->
//    pop 0xA0, push 0xA4. occupancy stays 4.
//  5 Bubble collapse: push 0x11, idle 2 cycles, push 0x22, out_ready=0 ->
//    occupancy=2 and both words are delivered in order once out_ready=1.
//  6 Flush (MUX_PIPE_FLUSH_EN): occupancy=3, flush=1 with in_valid=1 ->
//    next cycle occupancy=0, out_valid=0, input not accepted.

Source files
------------

// File: rtl/mux_dff_pipe.sv
// mux_dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Each stage is a mux-hold register: it either loads its upstream word or
// recirculates its own output. Valid/ready flow control collapses bubbles
// and stalls the whole chain when the consumer holds off.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      async active-low reset (all stages invalid, data=RESET_VAL)
//   in_valid   producer has a word on in_data
//   in_ready   pipeline accepts in_data this cycle (combinational from out_ready)
//   in_data    input word
//   out_valid  last stage holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   last stage data
//   occupancy  registered count of valid stages
//   flush      sync clear of all valid bits (only with MUX_PIPE_FLUSH_EN)
//
// Optional feature macro: MUX_PIPE_FLUSH_EN adds the flush input.

// One pipeline stage: a D register whose next value comes from a 2:1 mux
// (upstream word vs. own output).
module mux_dff_stage #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clr,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_data,
    output logic             vld,
    output logic [WIDTH-1:0] data
);
    logic [WIDTH-1:0] data_nxt;
    logic             vld_nxt;

    // Hold mux: without load the register sees its own output.
    assign data_nxt = (load && !clr) ? up_data : data;
    assign vld_nxt  = clr ? 1'b0 : (load ? up_vld : vld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= RESET_VAL;
        end else begin
            vld  <= vld_nxt;
            data <= data_nxt;
        end
    end
endmodule

module mux_dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef MUX_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    output logic [OCC_W-1:0] occupancy
);
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] data_pipe;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic                        flush_act;
    logic                        push;
    logic                        pop;

`ifdef MUX_PIPE_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Advance ripples back from the consumer: a stage may move on if the
    // next stage is empty or itself moving on.
    assign adv[DEPTH-1] = out_ready;
    genvar i;
    generate
        for (i = 0; i < DEPTH - 1; i++) begin : g_adv
            assign adv[i] = !vld_pipe[i+1] || adv[i+1];
        end

        for (i = 0; i < DEPTH; i++) begin : g_stage
            // An empty stage always loads, which is what closes bubbles.
            assign load[i] = !vld_pipe[i] || adv[i];
            if (i == 0) begin : g_head
                mux_dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .load    (load[i]),
                    .clr     (flush_act),
                    .up_vld  (in_valid),
                    .up_data (in_data),
                    .vld     (vld_pipe[i]),
                    .data    (data_pipe[i])
                );
            end else begin : g_body
                mux_dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .load    (load[i]),
                    .clr     (flush_act),
                    .up_vld  (vld_pipe[i-1]),
                    .up_data (data_pipe[i-1]),
                    .vld     (vld_pipe[i]),
                    .data    (data_pipe[i])
                );
            end
        end
    endgenerate

    assign in_ready  = load[0] && !flush_act;
    assign out_valid = vld_pipe[DEPTH-1];
    assign out_data  = data_pipe[DEPTH-1];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Registered count; equals the number of set valid bits at all times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush_act) begin
            occupancy <= '0;
        end else if (push && !pop) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (pop && !push) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end
endmodule

// File: tb/tb_mux_dff_pipe.sv
// Bench for mux_dff_pipe (WIDTH=8, DEPTH=4): scoreboard queue filled on
// accepted input and drained on consumed output, plus directed checks of
// reset, streaming latency, fill/stall, simultaneous push/pop, bubble
// collapse and (with MUX_PIPE_FLUSH_EN) flush.
module tb_mux_dff_pipe;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, flush;
    logic [7:0] in_data, out_data;
    logic [2:0] occupancy;

    logic [7:0] q[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, first_in = -1, first_out = -1, acc_cnt = 0, pop_cnt = 0;

    mux_dff_pipe #(.WIDTH(8), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef MUX_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at negedge, update scoreboard, then move past posedge.
    task automatic step();
        @(negedge clk);
        chk("occ", 32'(occupancy), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(((q.size() < DEPTH) || out_ready) && !flush));
        if (in_valid && in_ready) begin
            q.push_back(in_data);
            acc_cnt++;
            if (first_in < 0) first_in = cyc;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious", 1, 0);
            else chk("data", 32'(out_data), 32'(q.pop_front()));
            pop_cnt++;
            if (first_out < 0) first_out = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) step();
        chk("drain", 32'(q.size()), 0);
        chk("empty_ov", 32'(out_valid), 0);
    endtask

    initial begin
        int idx, acc0, pop0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
        #12;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ir", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming 0x01..0x10 with out_ready high.
        out_ready = 1'b1;
        first_in = -1; first_out = -1; pop0 = pop_cnt;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            step();
        end
        drain();
        chk("latency", 32'(first_out - first_in), 4);
        chk("stream_cnt", 32'(pop_cnt - pop0), 16);

        // Fill and stall.
        out_ready = 1'b0; idx = 0; acc0 = acc_cnt;
        repeat (6) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(idx);
            step();
            idx = acc_cnt - acc0;
        end
        chk("fill_acc", 32'(idx), 4);
        chk("full_ir", 32'(in_ready), 0);
        chk("full_occ", 32'(occupancy), 4);
        chk("full_data", 32'(out_data), 32'hA0);
        chk("full_ov", 32'(out_valid), 1);

        // Simultaneous pop 0xA0 / push 0xA4.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA4;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("simul_occ", 32'(occupancy), 4);
        chk("simul_data", 32'(out_data), 32'hA1);
        drain();

        // Reset in the middle of a stream with three words in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'hB0 + 8'(k);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_occ", 32'(occupancy), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 0);
        chk("mid_rst_occ", 32'(occupancy), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        q.delete();
        #1 rst_n = 1'b1;

        // Bubble collapse while stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'h22; step();
        in_valid = 1'b0; step();
        chk("bubble_occ", 32'(occupancy), 2);
        pop0 = pop_cnt;
        drain();
        chk("bubble_cnt", 32'(pop_cnt - pop0), 2);

        // Random traffic against the scoreboard.
        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            step();
        end
        drain();

`ifdef MUX_PIPE_FLUSH_EN
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(k);
            step();
        end
        chk("pre_fl_occ", 32'(occupancy), 3);
        in_valid = 1'b1; in_data = 8'hCF; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("fl_occ", 32'(occupancy), 0);
        chk("fl_ov", 32'(out_valid), 0);
        step();
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
